// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command bus between the RX FIFO, the command parser and board control.
// The parser is the master: it pulls bytes and pushes decoded commands.
interface uart_cmd_parser_if;
    logic        EMPTY;
    logic [7:0]  RX_DATA;
    logic        RE_N;
    logic        CMD_VALID;
    logic [7:0]  CMD_CODE;
    logic [7:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        FRAME_ERR;
    logic [7:0]  ERR_COUNT;

    modport master (
        input  EMPTY, RX_DATA,
        output RE_N, CMD_VALID, CMD_CODE, CMD_ADDR, CMD_DATA, FRAME_ERR, ERR_COUNT
    );

    modport slave (
        output EMPTY, RX_DATA,
        input  RE_N, CMD_VALID, CMD_CODE, CMD_ADDR, CMD_DATA, FRAME_ERR, ERR_COUNT
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Drains the RX byte FIFO, frames 7-byte sync/cmd/addr/data/checksum packets and
// strobes each validated command; bad checksums and stalled frames raise FRAME_ERR.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC0   = 8'h55,
    parameter logic [7:0]  SYNC1   = 8'hAA,
    parameter logic [19:0] TIMEOUT = 20'd100000
) (
    input logic               PCLK,
    input logic               PRESETN,
    uart_cmd_parser_if.master bus
);
    // Compared against the registered count so FRAME_ERR lands TIMEOUT cycles after the byte.
    localparam logic [19:0] TMO_LAST = TIMEOUT - 20'd2;

    typedef enum logic [1:0] {F_IDLE, F_RD, F_DAT} fetch_e;
    typedef enum logic [2:0] {S_SYNC0, S_SYNC1, S_CMD, S_ADDR, S_DH, S_DL, S_CHK} parse_e;

    fetch_e      fetch_q, fetch_d;
    parse_e      state_q, state_d;
    logic [7:0]  code_q, code_d, addr_q, addr_d, dh_q, dh_d, dl_q, dl_d, chk_q, chk_d;
    logic [19:0] tmr_q, tmr_d;
    logic        cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d;
    logic [7:0]  cmd_code_q, cmd_code_d, cmd_addr_q, cmd_addr_d, err_cnt_q, err_cnt_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic        byte_vld;
    logic [7:0]  rx_byte;

    always_comb begin
        fetch_d = fetch_q;
        unique case (fetch_q)
            F_IDLE:  if (!bus.EMPTY) fetch_d = F_RD;
            F_RD:    fetch_d = bus.EMPTY ? F_IDLE : F_DAT;
            F_DAT:   fetch_d = F_IDLE;
            default: fetch_d = F_IDLE;
        endcase
    end

    assign byte_vld = (fetch_q == F_DAT);
    assign rx_byte  = bus.RX_DATA;
    // Gated so a read can never be issued against an empty FIFO or during reset.
    assign bus.RE_N = ~(PRESETN && (fetch_q == F_RD) && !bus.EMPTY);

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        addr_d      = addr_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        chk_d       = chk_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;

        if (byte_vld) begin
            unique case (state_q)
                S_SYNC0: if (rx_byte == SYNC0) state_d = S_SYNC1;
                S_SYNC1: begin
                    if (rx_byte == SYNC1) begin
                        state_d = S_CMD;
                    end else if (rx_byte != SYNC0) begin
                        state_d = S_SYNC0;
                    end
                end
                S_CMD: begin
                    code_d  = rx_byte;
                    chk_d   = rx_byte;
                    state_d = S_ADDR;
                end
                S_ADDR: begin
                    addr_d  = rx_byte;
                    chk_d   = chk_q ^ rx_byte;
                    state_d = S_DH;
                end
                S_DH: begin
                    dh_d    = rx_byte;
                    chk_d   = chk_q ^ rx_byte;
                    state_d = S_DL;
                end
                S_DL: begin
                    dl_d    = rx_byte;
                    chk_d   = chk_q ^ rx_byte;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (rx_byte == chk_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = code_q;
                        cmd_addr_d  = addr_q;
                        cmd_data_d  = {dh_q, dl_q};
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_SYNC0;
                end
                default: state_d = S_SYNC0;
            endcase
        end else if ((state_q != S_SYNC0) && (tmr_q == TMO_LAST)) begin
            frame_err_d = 1'b1;
            state_d     = S_SYNC0;
        end

        tmr_d     = (byte_vld || (state_d == S_SYNC0)) ? 20'd0 : tmr_q + 20'd1;
        err_cnt_d = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            fetch_q     <= F_IDLE;
            state_q     <= S_SYNC0;
            code_q      <= 8'd0;
            addr_q      <= 8'd0;
            dh_q        <= 8'd0;
            dl_q        <= 8'd0;
            chk_q       <= 8'd0;
            tmr_q       <= 20'd0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_code_q  <= 8'd0;
            cmd_addr_q  <= 8'd0;
            cmd_data_q  <= 16'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            fetch_q     <= fetch_d;
            state_q     <= state_d;
            code_q      <= code_d;
            addr_q      <= addr_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            chk_q       <= chk_d;
            tmr_q       <= tmr_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            cmd_code_q  <= cmd_code_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.CMD_VALID = cmd_valid_q;
    assign bus.FRAME_ERR = frame_err_q;
    assign bus.CMD_CODE  = cmd_code_q;
    assign bus.CMD_ADDR  = cmd_addr_q;
    assign bus.CMD_DATA  = cmd_data_q;
    assign bus.ERR_COUNT = err_cnt_q;
endmodule
